bank_swap_ctrl: RTL and testbench

BANK_SWAP_CTRL -- requirements
Module: bank_swap_ctrl

---
 rtl/video_pkg.sv | 14 +
 rtl/mod_counter.sv | 26 ++
 rtl/bank_swap_ctrl.sv | 116 +++++++++++
 tb/tb_bank_swap_ctrl.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared video frame geometry and write-side state encoding for the bank swap path.
package video_pkg;

  localparam int unsigned X_WIDTH      = 8;
  localparam int unsigned Y_HEIGHT     = 6;
  localparam int unsigned FRAME_PIXELS = X_WIDTH * Y_HEIGHT;
  localparam int unsigned ADDR_W       = $clog2(FRAME_PIXELS);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } wr_state_e;

endpackage

// File: rtl/mod_counter.sv
// Modulo-N up counter with enable and synchronous clear; wrap_c flags the enabled terminal count.
module mod_counter #(
  parameter int unsigned MODULUS = 48,
  parameter int unsigned W       = 6
) (
  input  logic         CLK_40,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap_c
);

  localparam logic [W-1:0] LAST = W'(MODULUS - 1);

  assign wrap_c = en & (count == LAST);

  always_ff @(posedge CLK_40) begin
    if (reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap_c ? '0 : count + W'(1);
    end
  end

endmodule

// File: rtl/bank_swap_ctrl.sv
// Double-buffered frame bank controller: fills the write bank from the SPI bit stream and
// swaps banks with the display only when a full frame is stored and the reader wraps.
module bank_swap_ctrl #(
  parameter  int unsigned X_WIDTH      = video_pkg::X_WIDTH,
  parameter  int unsigned Y_HEIGHT     = video_pkg::Y_HEIGHT,
  localparam int unsigned FRAME_PIXELS = X_WIDTH * Y_HEIGHT,
  localparam int unsigned ADDR_W       = $clog2(FRAME_PIXELS)
) (
  input  logic              CLK_40,
  input  logic              reset,
  input  logic              video_bank_we,
  input  logic              SPI_clk_en,
  input  logic              MISO,
  input  logic              read_pixel_clk_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_data,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              video_bank_sel,
  output logic              frame_swap,
  output logic              overrun,
  output logic [7:0]        repeat_cnt
);

  import video_pkg::*;

  wr_state_e         state;
  logic              swap_pend;
  logic [ADDR_W-1:0] wr_ptr;
  logic              accept_c;
  logic              drop_c;
  logic              final_c;
  logic              rd_wrap_c;
  logic              swap_c;
  logic              late_swap_c;

  assign accept_c    = SPI_clk_en & video_bank_we & (state == FILL);
  assign drop_c      = SPI_clk_en & video_bank_we & (state == FULL);
  // A late swap lets the final bit land in the old bank before the banks flip.
  assign late_swap_c = rd_wrap_c & final_c;
  assign swap_c      = swap_pend | (rd_wrap_c & (state == FULL));

  mod_counter #(
    .MODULUS (FRAME_PIXELS),
    .W       (ADDR_W)
  ) u_wr_ptr (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .en     (accept_c),
    .clr    (swap_c),
    .count  (wr_ptr),
    .wrap_c (final_c)
  );

  mod_counter #(
    .MODULUS (FRAME_PIXELS),
    .W       (ADDR_W)
  ) u_rd_ptr (
    .CLK_40 (CLK_40),
    .reset  (reset),
    .en     (read_pixel_clk_en),
    .clr    (1'b0),
    .count  (rd_addr),
    .wrap_c (rd_wrap_c)
  );

  // Write FSM with registered write port, swap pulse and status outputs.
  always_ff @(posedge CLK_40) begin
    if (reset) begin
      state          <= FILL;
      swap_pend      <= 1'b0;
      wr_bank        <= 1'b1;
      video_bank_sel <= 1'b0;
      wr_en          <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= 1'b0;
      frame_swap     <= 1'b0;
      overrun        <= 1'b0;
      repeat_cnt     <= '0;
    end else begin
      wr_en      <= accept_c;
      frame_swap <= swap_c;
      swap_pend  <= late_swap_c;
      if (accept_c) begin
        wr_addr <= wr_ptr;
        wr_data <= MISO;
      end
      case (state)
        FILL: begin
          if (final_c) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (swap_c) begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
      if (swap_c) begin
        wr_bank        <= ~wr_bank;
        video_bank_sel <= wr_bank;
      end
      if (drop_c) begin
        overrun <= 1'b1;
      end
      // Reader wrapped while the next frame is still incomplete: the old frame is shown again.
      if (rd_wrap_c && (state == FILL) && !final_c && (repeat_cnt != 8'hFF)) begin
        repeat_cnt <= repeat_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_bank_swap_ctrl.sv
// Self-checking bench for bank_swap_ctrl: directed scenarios plus a randomized run against a frame-level model.
module tb_bank_swap_ctrl;

  localparam int FP = 48;

  logic       CLK_40 = 1'b0;
  logic       reset = 1'b1;
  logic       video_bank_we = 1'b0;
  logic       SPI_clk_en = 1'b0;
  logic       MISO = 1'b0;
  logic       read_pixel_clk_en = 1'b0;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic       wr_data;
  logic       wr_bank;
  logic [5:0] rd_addr;
  logic       video_bank_sel;
  logic       frame_swap;
  logic       overrun;
  logic [7:0] repeat_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame-level reference model state
  int m_cnt, m_rd, m_rep;
  bit m_full, m_pend, m_bank, m_ov;
  bit e_wr_en, e_data, e_fs;
  int e_addr;

  bank_swap_ctrl dut (
    .CLK_40            (CLK_40),
    .reset             (reset),
    .video_bank_we     (video_bank_we),
    .SPI_clk_en        (SPI_clk_en),
    .MISO              (MISO),
    .read_pixel_clk_en (read_pixel_clk_en),
    .wr_en             (wr_en),
    .wr_addr           (wr_addr),
    .wr_data           (wr_data),
    .wr_bank           (wr_bank),
    .rd_addr           (rd_addr),
    .video_bank_sel    (video_bank_sel),
    .frame_swap        (frame_swap),
    .overrun           (overrun),
    .repeat_cnt        (repeat_cnt)
  );

  always #5 CLK_40 = ~CLK_40;

  // Model: count pixels of the frame being stored; a swap needs a whole frame and a reader wrap.
  task automatic model_step(input bit r, input bit spi, input bit we, input bit miso_b, input bit rd);
    bit wrap, acc, fin, swp;
    if (r) begin
      m_cnt = 0; m_rd = 0; m_rep = 0; m_full = 0; m_pend = 0; m_bank = 1; m_ov = 0;
      e_wr_en = 0; e_addr = 0; e_data = 0; e_fs = 0;
      return;
    end
    wrap = rd && (m_rd == FP - 1);
    acc  = spi && we && !m_full;
    fin  = acc && (m_cnt == FP - 1);
    swp  = m_pend || (wrap && m_full);
    e_wr_en = acc;
    if (acc) begin
      e_addr = m_cnt;
      e_data = miso_b;
    end
    e_fs = swp;
    if (spi && we && m_full) m_ov = 1;
    if (wrap && !m_full && !fin && m_rep < 255) m_rep++;
    m_pend = wrap && fin;
    if (acc) m_cnt++;
    if (fin) m_full = 1;
    if (swp) begin
      m_bank = !m_bank;
      m_cnt  = 0;
      m_full = 0;
    end
    if (rd) m_rd = (m_rd + 1) % FP;
  endtask

  task automatic tick(input bit r, input bit spi, input bit we, input bit miso_b, input bit rd);
    reset = r; SPI_clk_en = spi; video_bank_we = we; MISO = miso_b; read_pixel_clk_en = rd;
    model_step(r, spi, we, miso_b, rd);
    @(posedge CLK_40);
    #1;
  endtask

  task automatic test_reset();
    int bad = 0;
    tick(1, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 100; i++) begin
      tick(0, 0, 0, 0, 0);
      if ({video_bank_sel, wr_bank, wr_en, wr_addr, wr_data, rd_addr, frame_swap, overrun, repeat_cnt}
          !== {1'b0, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 8'd0}) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL reset_idle: %0d bad cycles, last sel=%b bank=%b wr_en=%b rd=%0d rep=%0d, required sel=0 bank=1 rest 0",
               bad, video_bank_sel, wr_bank, wr_en, rd_addr, repeat_cnt);
    end
  endtask

  task automatic test_fill_swap();
    int bad = 0, fs_cnt = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < FP; i++) begin
      tick(0, 1, 1, (i % 2) == 0, 0);
      if (wr_en !== 1'b1 || wr_addr !== 6'(i) || wr_data !== ((i % 2) == 0) || wr_bank !== 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL fill_writes: %0d bad writes, required addr 0..47 bank 1 data alternating", bad);
    end
    bad = 0;
    for (int i = 0; i < FP; i++) begin
      tick(0, 0, 1, 0, 1);
      if (frame_swap === 1'b1) fs_cnt++;
      if (wr_en !== 1'b0) bad++;
    end
    n_tests++;
    if (fs_cnt != 1 || bad != 0 || frame_swap !== 1'b1) begin
      n_fail++;
      $display("FAIL fill_swap_pulse: got %0d pulses (last=%b), %0d stray writes; required 1 pulse on wrap, 0 writes",
               fs_cnt, frame_swap, bad);
    end
    n_tests++;
    if (video_bank_sel !== 1'b1 || wr_bank !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_banks: got sel=%b bank=%b, required sel=1 bank=0", video_bank_sel, wr_bank);
    end
    tick(0, 1, 1, 1, 0);
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_bank !== 1'b0 || frame_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL fill_next_write: got en=%b addr=%0d bank=%b fs=%b, required en=1 addr=0 bank=0 fs=0",
               wr_en, wr_addr, wr_bank, frame_swap);
    end
  endtask

  task automatic test_repeat();
    int fs_cnt = 0;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 2 * FP; i++) begin
      tick(0, 0, 0, 0, 1);
      if (frame_swap === 1'b1) fs_cnt++;
    end
    n_tests++;
    if (repeat_cnt !== 8'd2 || fs_cnt != 0 || video_bank_sel !== 1'b0 || wr_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL repeat_two: got rep=%0d pulses=%0d sel=%b, required rep=2 pulses=0 sel=0",
               repeat_cnt, fs_cnt, video_bank_sel);
    end
  endtask

  task automatic test_repeat_saturate();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 260 * FP; i++) tick(0, 0, 0, 0, 1);
    n_tests++;
    if (repeat_cnt !== 8'd255) begin
      n_fail++;
      $display("FAIL repeat_saturate: got rep=%0d, required 255", repeat_cnt);
    end
  endtask

  task automatic test_overrun();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < FP; i++) tick(0, 1, 1, 1'($urandom_range(0, 1)), 0);
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_early: got overrun=%b after exactly one frame, required 0", overrun);
    end
    tick(0, 1, 1, 1, 0);
    n_tests++;
    if (wr_en !== 1'b0 || overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got en=%b ov=%b, required en=0 ov=1", wr_en, overrun);
    end
    for (int i = 0; i < FP; i++) tick(0, 0, 1, 0, 1);
    n_tests++;
    if (overrun !== 1'b1 || video_bank_sel !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_sticky: got ov=%b sel=%b after swap, required ov=1 sel=1", overrun, video_bank_sel);
    end
  endtask

  task automatic test_same_cycle();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < FP - 1; i++) tick(0, 1, 1, 0, 1);
    tick(0, 1, 1, 1, 1);
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd47 || wr_bank !== 1'b1 || wr_data !== 1'b1 ||
        frame_swap !== 1'b0 || video_bank_sel !== 1'b0 || rd_addr !== 6'd0) begin
      n_fail++;
      $display("FAIL same_cycle_write: got en=%b addr=%0d bank=%b data=%b fs=%b sel=%b rd=%0d, required 1,47,1,1,0,0,0",
               wr_en, wr_addr, wr_bank, wr_data, frame_swap, video_bank_sel, rd_addr);
    end
    tick(0, 0, 1, 0, 0);
    n_tests++;
    if (frame_swap !== 1'b1 || video_bank_sel !== 1'b1 || wr_bank !== 1'b0 || repeat_cnt !== 8'd0 || wr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_swap: got fs=%b sel=%b bank=%b rep=%0d en=%b, required fs=1 sel=1 bank=0 rep=0 en=0",
               frame_swap, video_bank_sel, wr_bank, repeat_cnt, wr_en);
    end
    tick(0, 0, 1, 0, 0);
    n_tests++;
    if (frame_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_pulse_width: got fs=%b, required 0", frame_swap);
    end
  endtask

  task automatic test_reset_mid();
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) tick(0, i < 20, 1, 1, 1);
    n_tests++;
    if (rd_addr !== 6'd30 || wr_addr !== 6'd19) begin
      n_fail++;
      $display("FAIL reset_mid_setup: got rd=%0d last_addr=%0d, required rd=30 last_addr=19", rd_addr, wr_addr);
    end
    tick(1, 1, 1, 1, 1);
    n_tests++;
    if (wr_en !== 1'b0 || frame_swap !== 1'b0 || rd_addr !== 6'd0 || wr_bank !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_clear: got en=%b fs=%b rd=%0d bank=%b, required 0,0,0,1",
               wr_en, frame_swap, rd_addr, wr_bank);
    end
    tick(0, 1, 1, 1, 0);
    n_tests++;
    if (wr_en !== 1'b1 || wr_addr !== 6'd0 || wr_bank !== 1'b1 || rd_addr !== 6'd0 || frame_swap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got en=%b addr=%0d bank=%b rd=%0d fs=%b, required 1,0,1,0,0",
               wr_en, wr_addr, wr_bank, rd_addr, frame_swap);
    end
  endtask

  task automatic test_random();
    int bad = 0, bad_wr = 0, swaps = 0;
    bit r, spi, we, mb, rd;
    tick(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      r   = ($urandom_range(0, 599) == 0);
      spi = $urandom_range(0, 1) == 1;
      we  = $urandom_range(0, 7) != 0;
      mb  = $urandom_range(0, 1) == 1;
      rd  = $urandom_range(0, 1) == 1;
      tick(r, spi, we, mb, rd);
      if (frame_swap === 1'b1) swaps++;
      n_tests++;
      if ({wr_en, wr_bank, video_bank_sel, frame_swap, overrun, rd_addr, repeat_cnt} !==
          {e_wr_en, m_bank, !m_bank, e_fs, m_ov, 6'(m_rd), 8'(m_rep)}) begin
        n_fail++;
        if (bad < 5)
          $display("FAIL random_ctrl cyc %0d: got en=%b bank=%b sel=%b fs=%b ov=%b rd=%0d rep=%0d, required %b %b %b %b %b %0d %0d",
                   i, wr_en, wr_bank, video_bank_sel, frame_swap, overrun, rd_addr, repeat_cnt,
                   e_wr_en, m_bank, !m_bank, e_fs, m_ov, m_rd, m_rep);
        bad++;
      end
      if (e_wr_en) begin
        n_tests++;
        if (wr_addr !== 6'(e_addr) || wr_data !== e_data) begin
          n_fail++;
          if (bad_wr < 5)
            $display("FAIL random_write cyc %0d: got addr=%0d data=%b, required addr=%0d data=%b",
                     i, wr_addr, wr_data, e_addr, e_data);
          bad_wr++;
        end
      end
    end
    n_tests++;
    if (swaps == 0) begin
      n_fail++;
      $display("FAIL random_coverage: got %0d swaps, required at least 1", swaps);
    end
  endtask

  initial begin
    test_reset();
    test_fill_swap();
    test_repeat();
    test_overrun();
    test_same_cycle();
    test_reset_mid();
    test_repeat_saturate();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
